csr_pins_in: RTL and testbench
==============================

CSR_PINS_IN -- requirements
Module: csr_pins_in

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hbc2, CSR address of the PINS register; EDGE is BASE_ADDR+1, POL is BASE_ADDR+2.
REQ-002 SHALL have parameter COUNT, default 8, number of input pins, legal range 1..32.
REQ-003 SHALL have parameter DEBOUNCE, default 16, required consecutive stable cycles; 0 means bypass.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk and rstn.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 read  input  1  CSR read strobe; informational only, no effect on state.
REQ-008 modify  input  3  CSR op: 001 write, 010 set, 011 clear, other values no-op.
REQ-009 wdata  input  32  CSR write data.
REQ-010 addr  input  12  CSR address.
REQ-011 rdata  output  32  registered read data; all zero when not addressed.
REQ-012 valid  output  1  registered; high when the previous cycle's addr hit this block.
REQ-013 pins  input  COUNT  asynchronous external inputs.
REQ-014 irq  output  1  OR of EDGE & ~0 flags; driven from registers, no combinational path from inputs.

Function
REQ-015 Each pin SHALL pass through a 2-FF synchronizer, giving sync[i].
REQ-016 DEBOUNCE=0: state[i] SHALL equal sync[i]; pin-to-state latency 2 cycles.
REQ-017 DEBOUNCE>0, per pin per edge: sync==state -> cnt<=0; else cnt==DEBOUNCE-1 -> state<=sync, cnt<=0; else cnt<=cnt+1.
REQ-018 A clean pin transition SHALL reach state[i] exactly 2+DEBOUNCE cycles after the first capturing edge; pulses shorter than DEBOUNCE sync cycles SHALL be ignored.
REQ-019 Counter width SHALL be $clog2(max(DEBOUNCE,2)); counters never wrap past DEBOUNCE-1.
REQ-020 Edge event for pin i SHALL fire on the edge state[i] updates: rising (0->1) if POL[i]=0, falling (1->0) if POL[i]=1.
REQ-021 An edge event SHALL set EDGE[i] on the same clock edge state[i] changes.
REQ-022 CSR response SHALL be one cycle latency: on edge after addr in {BASE, BASE+1, BASE+2}, valid<=1 and rdata<=pre-modify value zero-extended to 32 bits; otherwise valid<=0, rdata<=0.
REQ-023 PINS register SHALL be read-only; modify ops to BASE_ADDR are ignored but still produce valid.
REQ-024 EDGE/POL modify: write reg<=wdata[COUNT-1:0]; set reg|=wdata; clear reg&=~wdata.
REQ-025 Simultaneous edge event and EDGE clear/write on the same bit: the event SHALL win (bit ends 1).
REQ-026 Changing POL SHALL NOT itself generate an edge event.
REQ-027 Unused rdata bits [31:COUNT] SHALL read zero.

Reset
REQ-028 rstn low SHALL asynchronously clear synchronizers, state, cnt, EDGE, POL, valid, rdata; irq therefore 0.
REQ-029 A pin held high through reset SHALL produce one rising event 2+DEBOUNCE cycles after rstn deasserts (documented behaviour, not suppressed).
REQ-030 Reset mid-debounce SHALL discard partial count; no event is generated for the aborted transition.

Structure
REQ-031 CSR modify encodings (WRITE, SET, CLEAR) SHALL live in the shared CSR package, used by all Csr* peripherals.
REQ-032 Per-pin synchronizer+debounce SHALL be one sub-module, pin_debounce, instantiated COUNT times via generate.
REQ-033 Block SHALL be OR-bus compatible: rdata/valid zero whenever not addressed.

Verification
REQ-034 DEBOUNCE=4, pins[0] 0->1 at cycle 0 -> PINS bit0 reads 1 from cycle 6, EDGE=0x01, irq=1.
REQ-035 DEBOUNCE=4, pins[3] high pulse of 3 cycles -> PINS and EDGE unchanged, irq stays 0.
REQ-036 POL=0x02, pins[1] 1->0 -> EDGE=0x02; then clear wdata=0x02 to BASE+1 -> EDGE=0, irq=0 next cycle.
REQ-037 Edge event on bit2 coincident with clear wdata=0x04 -> EDGE bit2=1 after that edge.
REQ-038 Read addr=BASE+3 -> valid=0, rdata=0; write 0xFF to BASE -> valid=1, PINS unaffected.
REQ-039 rstn asserted with pins=0xFF mid-count -> all outputs 0 immediately; after release one rising event per pin, EDGE=0xFF.

Source files
------------

// File: rtl/csr_pins_in_pkg.sv
// Shared CSR definitions: modify-op encodings used by every Csr* peripheral,
// plus a helper for sizing debounce counters.
package csr_pins_in_pkg;

    localparam int unsigned CsrAddrW = 12;
    localparam int unsigned CsrDataW = 32;

    typedef enum logic [2:0] {
        CsrNop   = 3'b000,
        CsrWrite = 3'b001,
        CsrSet   = 3'b010,
        CsrClear = 3'b011
    } csr_op_e;

    // Counter just wide enough to hold Debounce-1, never narrower than 1 bit.
    function automatic int unsigned dbnc_cnt_width(input int unsigned debounce);
        return $clog2(debounce > 2 ? debounce : 2);
    endfunction

endpackage

// File: rtl/pin_debounce.sv
// One input pin: 2-FF synchronizer followed by an optional consecutive-cycle
// debouncer. Reports when the debounced state is about to change on this edge
// and what it changes to, so the parent can flag edges in the same cycle.
module pin_debounce
    import csr_pins_in_pkg::*;
#(
    parameter int unsigned Debounce = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic state_o,
    output logic chg_o,
    output logic next_o
);

    logic sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    if (Debounce == 0) begin : g_bypass
        // State is the synchronizer output; it changes whenever sync1 differs.
        assign state_o = sync2_q;
        assign chg_o   = sync1_q ^ sync2_q;
        assign next_o  = sync1_q;
    end else begin : g_debounce
        localparam int unsigned CntW = dbnc_cnt_width(Debounce);
        localparam logic [CntW-1:0] CntMax = CntW'(Debounce - 1);

        logic            state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;

        // Count consecutive cycles where sync disagrees with state; commit at CntMax.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (sync2_q == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                state_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        // Debounced state and counter registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign state_o = state_q;
        assign chg_o   = state_d ^ state_q;
        assign next_o  = state_d;
    end

endmodule

// File: rtl/csr_pins_in.sv
// Debounced input pins exposed through three CSRs: PINS (read-only state),
// EDGE (sticky edge flags, drives irq) and POL (per-pin edge polarity).
module csr_pins_in
    import csr_pins_in_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'hbc2,
    parameter int unsigned COUNT     = 8,
    parameter int unsigned DEBOUNCE  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             read,
    input  logic [2:0]       modify,
    input  logic [31:0]      wdata,
    input  logic [11:0]      addr,
    output logic [31:0]      rdata,
    output logic             valid,
    input  logic [COUNT-1:0] pins,
    output logic             irq
);

    localparam logic [11:0] AddrPins = BASE_ADDR;
    localparam logic [11:0] AddrEdge = BASE_ADDR + 12'd1;
    localparam logic [11:0] AddrPol  = BASE_ADDR + 12'd2;

    logic [COUNT-1:0] state, chg, nxt, ev;
    logic [COUNT-1:0] edge_q, edge_d, pol_q, pol_d, wmask, rd_val;
    logic [31:0]      rdata_q, rdata_d;
    logic             valid_q, valid_d;

    // The read strobe and upper write-data bits carry no meaning here.
    logic unused_sig;
    assign unused_sig = ^{read, wdata};

    for (genvar i = 0; i < COUNT; i++) begin : g_pin
        pin_debounce #(
            .Debounce(DEBOUNCE)
        ) u_pin (
            .clk_i  (clk),
            .rst_ni (rstn),
            .pin_i  (pins[i]),
            .state_o(state[i]),
            .chg_o  (chg[i]),
            .next_o (nxt[i])
        );
    end

    // Event when state flips toward the active level (POL=0 rising, POL=1 falling).
    assign ev    = chg & (nxt ^ pol_q);
    assign wmask = wdata[COUNT-1:0];

    function automatic logic [COUNT-1:0] apply_op(input logic [2:0]       op,
                                                  input logic [COUNT-1:0] cur,
                                                  input logic [COUNT-1:0] wd);
        case (csr_op_e'(op))
            CsrWrite: return wd;
            CsrSet:   return cur | wd;
            CsrClear: return cur & ~wd;
            default:  return cur;
        endcase
    endfunction

    // CSR decode, pre-modify readback and register updates; edge events win over clears.
    always_comb begin
        edge_d  = edge_q;
        pol_d   = pol_q;
        rd_val  = '0;
        valid_d = 1'b0;
        rdata_d = '0;
        case (addr)
            AddrPins: begin
                valid_d = 1'b1;
                rd_val  = state;
            end
            AddrEdge: begin
                valid_d = 1'b1;
                rd_val  = edge_q;
                edge_d  = apply_op(modify, edge_q, wmask);
            end
            AddrPol: begin
                valid_d = 1'b1;
                rd_val  = pol_q;
                pol_d   = apply_op(modify, pol_q, wmask);
            end
            default: ;
        endcase
        edge_d = edge_d | ev;
        rdata_d[COUNT-1:0] = rd_val;
    end

    // CSR state and registered response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_q  <= '0;
            pol_q   <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            edge_q  <= edge_d;
            pol_q   <= pol_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign irq   = |edge_q;

endmodule

// File: tb/tb_csr_pins_in.sv
// Directed bench for csr_pins_in with COUNT=8, DEBOUNCE=4.
module tb_csr_pins_in;

    localparam logic [11:0] Base = 12'hbc2;
    localparam logic [11:0] AEdge = Base + 12'd1;
    localparam logic [11:0] APol  = Base + 12'd2;
    localparam logic [2:0] OpNone = 3'b000;
    localparam logic [2:0] OpWr   = 3'b001;
    localparam logic [2:0] OpSet  = 3'b010;
    localparam logic [2:0] OpClr  = 3'b011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'b000;
    logic [31:0] wdata = '0;
    logic [11:0] addr = '0;
    logic [31:0] rdata;
    logic        valid;
    logic [7:0]  pins = '0;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd;
    logic        vd;

    csr_pins_in #(
        .BASE_ADDR(Base),
        .COUNT    (8),
        .DEBOUNCE (4)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .read  (read),
        .modify(modify),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .valid (valid),
        .pins  (pins),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one CSR access for a single cycle; return the registered response.
    task automatic csr(input logic [11:0] a, input logic [2:0] m, input logic [31:0] wd,
                       output logic [31:0] r, output logic v);
        addr   = a;
        modify = m;
        wdata  = wd;
        read   = 1'b1;
        @(negedge clk);
        r = rdata;
        v = valid;
        addr   = 12'h000;
        modify = OpNone;
        wdata  = '0;
        read   = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        rstn = 1'b1;
        tick(8);

        // Clean rising edge on pin0: event lands on the 6th edge
        pins = 8'h01;
        tick(5);
        chk("p0_irq_before", {31'b0, irq}, 32'h0);
        tick(1);
        chk("p0_irq_after", {31'b0, irq}, 32'h1);
        csr(Base, OpNone, 0, rd, vd);
        chk("p0_pins", rd, 32'h01);
        chk("p0_pins_valid", {31'b0, vd}, 32'h1);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("p0_edge", rd, 32'h01);
        csr(AEdge, OpClr, 32'h01, rd, vd);
        chk("p0_clr_premod", rd, 32'h01);
        chk("p0_clr_irq", {31'b0, irq}, 32'h0);

        // Short pulse (3 cycles) on pin3 is rejected
        pins = 8'h09;
        tick(3);
        pins = 8'h01;
        tick(10);
        chk("pulse3_irq", {31'b0, irq}, 32'h0);
        csr(Base, OpNone, 0, rd, vd);
        chk("pulse3_pins", rd, 32'h01);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("pulse3_edge", rd, 32'h00);

        // Pulse of exactly DEBOUNCE cycles on pin4 passes
        pins = 8'h11;
        tick(4);
        pins = 8'h01;
        tick(10);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("pulse4_edge", rd, 32'h10);
        csr(Base, OpNone, 0, rd, vd);
        chk("pulse4_pins", rd, 32'h01);
        csr(AEdge, OpWr, 32'h0, rd, vd);
        chk("pulse4_wr_irq", {31'b0, irq}, 32'h0);

        // Falling-edge polarity on pin1
        csr(APol, OpWr, 32'h02, rd, vd);
        csr(APol, OpNone, 0, rd, vd);
        chk("pol_read", rd, 32'h02);
        pins = 8'h03;
        tick(8);
        chk("pol_rise_ignored", {31'b0, irq}, 32'h0);
        pins = 8'h01;
        tick(8);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("pol_fall_edge", rd, 32'h02);
        chk("pol_fall_irq", {31'b0, irq}, 32'h1);
        csr(AEdge, OpClr, 32'h02, rd, vd);
        chk("pol_clr_irq", {31'b0, irq}, 32'h0);
        csr(APol, OpClr, 32'h02, rd, vd);
        chk("pol_change_no_event", {31'b0, irq}, 32'h0);

        // Edge event on pin2 coincident with a clear of the same bit: event wins
        pins = 8'h05;
        tick(5);
        csr(AEdge, OpClr, 32'h04, rd, vd);
        chk("race_premod", rd, 32'h00);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("race_edge", rd, 32'h04);
        chk("race_irq", {31'b0, irq}, 32'h1);
        csr(AEdge, OpWr, 32'h0, rd, vd);

        // Address decode and read-only PINS
        csr(Base + 12'd3, OpNone, 0, rd, vd);
        chk("miss_hi_valid", {31'b0, vd}, 32'h0);
        chk("miss_hi_rdata", rd, 32'h0);
        csr(Base - 12'd1, OpWr, 32'hFF, rd, vd);
        chk("miss_lo_valid", {31'b0, vd}, 32'h0);
        csr(Base, OpWr, 32'hFF, rd, vd);
        chk("ro_wr_valid", {31'b0, vd}, 32'h1);
        chk("ro_wr_rdata", rd, 32'h05);
        csr(Base, OpNone, 0, rd, vd);
        chk("ro_pins_kept", rd, 32'h05);

        // Reset mid-count with all pins high
        csr(APol, OpWr, 32'h0F, rd, vd);
        csr(AEdge, OpSet, 32'h80, rd, vd);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        pins = 8'hFF;
        tick(3);
        addr = Base;
        tick(1);
        chk("pre_rst_valid", {31'b0, valid}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_async_rdata", rdata, 32'h0);
        chk("rst_async_valid", {31'b0, valid}, 32'h0);
        chk("rst_async_irq", {31'b0, irq}, 32'h0);
        addr = 12'h000;
        tick(2);
        rstn = 1'b1;
        tick(5);
        chk("post_rst_irq_before", {31'b0, irq}, 32'h0);
        tick(1);
        chk("post_rst_irq_after", {31'b0, irq}, 32'h1);
        csr(AEdge, OpNone, 0, rd, vd);
        chk("post_rst_edge", rd, 32'hFF);
        csr(Base, OpNone, 0, rd, vd);
        chk("post_rst_pins", rd, 32'hFF);
        csr(APol, OpNone, 0, rd, vd);
        chk("post_rst_pol", rd, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
